// File: rtl/isa_host_master_if.sv
// AXI4-Lite slave-side channel bundle for the ISA host master bridge.
// The bridge uses the slave modport; the initiator (CPU side, or a bench) uses master.
interface isa_host_master_if;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/isa_host_master.sv
// AXI4-Lite to ISA 8-bit I/O cycle bridge: one transaction at a time, with
// programmable setup/strobe/hold timing, IOCHRDY wait states and a wait timeout.
module isa_host_master #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 6,
    parameter int HOLD_CYCLES   = 2,
    parameter int RDY_TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    reset_n,
    isa_host_master_if.slave        axi,
    output logic [9:0]              isa_addr,
    output logic [7:0]              isa_data_out,
    output logic                    isa_data_oe,
    input  logic [7:0]              isa_data_in,
    output logic                    isa_ior_n,
    output logic                    isa_iow_n,
    output logic                    isa_aen,
    input  logic                    isa_iochrdy,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    localparam logic [15:0] L_SETUP  = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] L_STROBE = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] L_HOLD   = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] L_TMO    = 16'(RDY_TIMEOUT - 1);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_go;
    logic        r_is_wr;
    logic        r_skip;
    logic        r_err;
    logic        r_awready;
    logic        r_wready;
    logic        r_arready;
    logic        r_bvalid;
    logic        r_rvalid;
    logic [1:0]  r_resp;
    logic [31:0] r_rdata;
    logic [9:0]  r_addr;
    logic [7:0]  r_dout;
    logic        r_oe;
    logic        r_ior_n;
    logic        r_iow_n;
    logic        r_timeout_err;
    logic        r_rdy_s1;
    logic        r_rdy_s2;

    logic w_rdy_s;
    logic w_strobe_done;
    logic w_abort;
    logic w_resp_done;
    logic w_unused;

    assign w_rdy_s       = r_rdy_s2;
    assign w_strobe_done = ((r_state == S_STROBE && r_cnt == 16'd0) || r_state == S_WAIT) && w_rdy_s;
    assign w_abort       = (r_state == S_WAIT) && !w_rdy_s && (r_cnt == L_TMO);
    assign w_resp_done   = (r_bvalid && axi.s_axi_bready) || (r_rvalid && axi.s_axi_rready);
    assign w_unused      = &{1'b0, axi.s_axi_awaddr[31:12], axi.s_axi_awaddr[1:0],
                             axi.s_axi_araddr[31:12], axi.s_axi_araddr[1:0],
                             axi.s_axi_wdata[31:8], axi.s_axi_wstrb[3:1]};

    // IOCHRDY is asynchronous to clk; idle-high so a reset never fakes a wait request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdy_s1 <= 1'b1;
            r_rdy_s2 <= 1'b1;
        end else begin
            r_rdy_s1 <= isa_iochrdy;
            r_rdy_s2 <= r_rdy_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 16'd0;
            r_go          <= 1'b0;
            r_is_wr       <= 1'b0;
            r_skip        <= 1'b0;
            r_err         <= 1'b0;
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_arready     <= 1'b0;
            r_bvalid      <= 1'b0;
            r_rvalid      <= 1'b0;
            r_resp        <= RESP_OKAY;
            r_rdata       <= 32'h0;
            r_addr        <= 10'h0;
            r_dout        <= 8'h0;
            r_oe          <= 1'b0;
            r_ior_n       <= 1'b1;
            r_iow_n       <= 1'b1;
            r_timeout_err <= 1'b0;
        end else begin
            r_awready     <= 1'b0;
            r_wready      <= 1'b0;
            r_arready     <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // r_go marks the clock between the AXI handshake and the start of SETUP
                    if (r_go) begin
                        r_go <= 1'b0;
                        if (r_skip) begin
                            r_resp   <= RESP_OKAY;
                            r_bvalid <= 1'b1;
                            r_state  <= S_RESP;
                        end else begin
                            r_oe    <= r_is_wr;
                            r_cnt   <= L_SETUP;
                            r_state <= S_SETUP;
                        end
                    end else if (r_awready) begin
                        r_go    <= 1'b1;
                        r_is_wr <= 1'b1;
                        r_err   <= 1'b0;
                        r_skip  <= !axi.s_axi_wstrb[0];
                        if (axi.s_axi_wstrb[0]) begin
                            r_addr <= axi.s_axi_awaddr[11:2];
                            r_dout <= axi.s_axi_wdata[7:0];
                        end
                    end else if (r_arready) begin
                        r_go    <= 1'b1;
                        r_is_wr <= 1'b0;
                        r_err   <= 1'b0;
                        r_skip  <= 1'b0;
                        r_addr  <= axi.s_axi_araddr[11:2];
                    end else if (axi.s_axi_awvalid && axi.s_axi_wvalid) begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end else if (axi.s_axi_arvalid) begin
                        r_arready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt   <= L_STROBE;
                        r_state <= S_STROBE;
                        if (r_is_wr) r_iow_n <= 1'b0;
                        else         r_ior_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_STROBE, S_WAIT: begin
                    // Read data is latched on the same edge that raises the strobe
                    if (w_strobe_done || w_abort) begin
                        r_ior_n <= 1'b1;
                        r_iow_n <= 1'b1;
                        r_cnt   <= L_HOLD;
                        r_state <= S_HOLD;
                        if (w_abort) begin
                            r_err         <= 1'b1;
                            r_timeout_err <= 1'b1;
                            if (!r_is_wr) r_rdata <= 32'h0000_00FF;
                        end else if (!r_is_wr) begin
                            r_rdata <= {24'h0, isa_data_in};
                        end
                    end else if (r_state == S_STROBE) begin
                        if (r_cnt == 16'd0) begin
                            r_cnt   <= 16'd0;
                            r_state <= S_WAIT;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == 16'd0) begin
                        r_oe    <= 1'b0;
                        r_resp  <= r_err ? RESP_SLVERR : RESP_OKAY;
                        r_state <= S_RESP;
                        if (r_is_wr) r_bvalid <= 1'b1;
                        else         r_rvalid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_bvalid <= 1'b0;
                        r_rvalid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign axi.s_axi_awready = r_awready;
    assign axi.s_axi_wready  = r_wready;
    assign axi.s_axi_arready = r_arready;
    assign axi.s_axi_bvalid  = r_bvalid;
    assign axi.s_axi_rvalid  = r_rvalid;
    assign axi.s_axi_bresp   = r_resp;
    assign axi.s_axi_rresp   = r_resp;
    assign axi.s_axi_rdata   = r_rdata;

    assign isa_addr     = r_addr;
    assign isa_data_out = r_dout;
    assign isa_data_oe  = r_oe;
    assign isa_ior_n    = r_ior_n;
    assign isa_iow_n    = r_iow_n;
    assign isa_aen      = 1'b0;
    assign busy         = (r_state != S_IDLE);
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_isa_host_master.sv
// Directed bench for isa_host_master: timing, wait states, timeout, arbitration, reset.
module tb_isa_host_master;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] isa_addr;
    logic [7:0] isa_data_out;
    logic       isa_data_oe;
    logic [7:0] isa_data_in;
    logic       isa_ior_n;
    logic       isa_iow_n;
    logic       isa_aen;
    logic       isa_iochrdy;
    logic       busy;
    logic       timeout_err;

    int n_chk = 0;
    int n_bad = 0;

    int n_ior = 0, n_iow = 0, n_both = 0, n_tmo = 0, n_oe_bad = 0;
    logic [7:0] mon_wd = 8'h0;
    logic [9:0] mon_addr = 10'h0;

    always #5 clk = ~clk;

    isa_host_master_if axi ();

    isa_host_master #(
        .SETUP_CYCLES (2),
        .STROBE_CYCLES(6),
        .HOLD_CYCLES  (2),
        .RDY_TIMEOUT  (1024)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .axi         (axi),
        .isa_addr    (isa_addr),
        .isa_data_out(isa_data_out),
        .isa_data_oe (isa_data_oe),
        .isa_data_in (isa_data_in),
        .isa_ior_n   (isa_ior_n),
        .isa_iow_n   (isa_iow_n),
        .isa_aen     (isa_aen),
        .isa_iochrdy (isa_iochrdy),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // ISA-side observer: strobe widths, overlap, data/address seen while a strobe is low
    always @(negedge clk) begin
        if (!isa_ior_n) n_ior++;
        if (!isa_iow_n) n_iow++;
        if (!isa_ior_n && !isa_iow_n) n_both++;
        if (timeout_err) n_tmo++;
        if (!isa_ior_n || !isa_iow_n) mon_addr = isa_addr;
        if (!isa_iow_n) begin
            mon_wd = isa_data_out;
            if (!isa_data_oe) n_oe_bad++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output int lat, output logic [1:0] resp);
        int k;
        axi.s_axi_awaddr  = a;
        axi.s_axi_wdata   = d;
        axi.s_axi_wstrb   = s;
        axi.s_axi_awvalid = 1'b1;
        axi.s_axi_wvalid  = 1'b1;
        k = 0;
        while (!(axi.s_axi_awready && axi.s_axi_wready) && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk("wr_ready", 32'(axi.s_axi_awready && axi.s_axi_wready), 32'h1);
        @(posedge clk); #1;
        axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wvalid  = 1'b0;
        lat = 0;
        while (!axi.s_axi_bvalid && lat < 3000) begin
            @(posedge clk); #1; lat++;
        end
        chk("wr_bvalid", 32'(axi.s_axi_bvalid), 32'h1);
        resp = axi.s_axi_bresp;
        axi.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        axi.s_axi_bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input int rdy_low,
                      output int lat, output logic [31:0] data, output logic [1:0] resp);
        int k;
        axi.s_axi_araddr  = a;
        axi.s_axi_arvalid = 1'b1;
        k = 0;
        while (!axi.s_axi_arready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk("rd_ready", 32'(axi.s_axi_arready), 32'h1);
        @(posedge clk); #1;
        axi.s_axi_arvalid = 1'b0;
        lat = 0;
        if (rdy_low > 0) begin
            while (isa_ior_n && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            isa_iochrdy = 1'b0;
            repeat (rdy_low) begin
                @(posedge clk); #1; lat++;
            end
            isa_iochrdy = 1'b1;
        end
        while (!axi.s_axi_rvalid && lat < 3000) begin
            @(posedge clk); #1; lat++;
        end
        chk("rd_rvalid", 32'(axi.s_axi_rvalid), 32'h1);
        data = axi.s_axi_rdata;
        resp = axi.s_axi_rresp;
        axi.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        axi.s_axi_rready = 1'b0;
    endtask

    initial begin
        int lat, b_ior, b_iow, b_tmo, b_oe, k, stale;
        logic [1:0]  resp;
        logic [31:0] data;

        axi.s_axi_awaddr = 32'h0; axi.s_axi_awvalid = 1'b0;
        axi.s_axi_wdata  = 32'h0; axi.s_axi_wstrb   = 4'h0; axi.s_axi_wvalid = 1'b0;
        axi.s_axi_bready = 1'b0;
        axi.s_axi_araddr = 32'h0; axi.s_axi_arvalid = 1'b0;
        axi.s_axi_rready = 1'b0;
        isa_data_in = 8'h00;
        isa_iochrdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", 32'({isa_ior_n, isa_iow_n}), 32'h3);
        chk("rst_oe_aen_busy", 32'({isa_data_oe, isa_aen, busy, timeout_err}), 32'h0);
        chk("rst_addr_data", 32'({isa_addr, isa_data_out}), 32'h0);
        chk("rst_axi_hs", 32'({axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready,
                               axi.s_axi_bvalid, axi.s_axi_rvalid}), 32'h0);
        chk("rst_rdata", axi.s_axi_rdata, 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Plain write to port 0x3F2
        b_iow = n_iow; b_oe = n_oe_bad;
        wr(32'h0000_0FC8, 32'hDEAD_BE1C, 4'hF, lat, resp);
        chk("w1_iow_width", n_iow - b_iow, 6);
        chk("w1_data", 32'(mon_wd), 32'h1C);
        chk("w1_oe_low_in_strobe", n_oe_bad - b_oe, 0);
        chk("w1_addr", 32'(mon_addr), 32'h3F2);
        chk("w1_latency", lat, 11);
        chk("w1_bresp", 32'(resp), 32'h0);
        chk("w1_idle_after", 32'({busy, isa_data_oe, axi.s_axi_bvalid}), 32'h0);

        // Plain read from port 0x3F4
        isa_data_in = 8'h80;
        b_ior = n_ior;
        rd(32'h0000_0FD0, 0, lat, data, resp);
        chk("r1_ior_width", n_ior - b_ior, 6);
        chk("r1_rdata", data, 32'h0000_0080);
        chk("r1_rresp", 32'(resp), 32'h0);
        chk("r1_latency", lat, 11);
        chk("r1_addr", 32'(mon_addr), 32'h3F4);

        // Byte lane 0 disabled: no ISA cycle, immediate OKAY
        b_iow = n_iow;
        wr(32'h0000_0100, 32'h0000_0055, 4'hE, lat, resp);
        chk("w2_no_strobe", n_iow - b_iow, 0);
        chk("w2_latency", lat, 1);
        chk("w2_bresp", 32'(resp), 32'h0);

        // 20 clocks of IOCHRDY low from strobe fall; upper/lower address bits ignored
        isa_data_in = 8'h5A;
        b_ior = n_ior; b_tmo = n_tmo;
        rd(32'hABCD_E3F7, 20, lat, data, resp);
        chk("r2_ior_width", n_ior - b_ior, 23);
        chk("r2_latency", lat, 28);
        chk("r2_no_timeout", n_tmo - b_tmo, 0);
        chk("r2_rdata", data, 32'h0000_005A);
        chk("r2_rresp", 32'(resp), 32'h0);
        chk("r2_addr", 32'(mon_addr), 32'h0FD);

        // IOCHRDY stuck low: abort after RDY_TIMEOUT wait clocks
        isa_data_in = 8'h33;
        isa_iochrdy = 1'b0;
        b_ior = n_ior; b_tmo = n_tmo;
        rd(32'h0000_0010, 0, lat, data, resp);
        isa_iochrdy = 1'b1;
        chk("r3_ior_width", n_ior - b_ior, 1030);
        chk("r3_timeout_pulse", n_tmo - b_tmo, 1);
        chk("r3_rresp", 32'(resp), 32'h2);
        chk("r3_rdata", data, 32'h0000_00FF);

        // AR, AW and W together: write first, read afterwards
        isa_data_in = 8'h77;
        b_ior = n_ior; b_iow = n_iow;
        axi.s_axi_awaddr = 32'h0000_0404; axi.s_axi_wdata = 32'h0000_00A5; axi.s_axi_wstrb = 4'h1;
        axi.s_axi_araddr = 32'h0000_0808;
        axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1; axi.s_axi_arvalid = 1'b1;
        k = 0;
        while (!axi.s_axi_awready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk("arb_write_first", 32'({axi.s_axi_awready, axi.s_axi_arready}), 32'h2);
        @(posedge clk); #1;
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
        k = 0;
        while (!axi.s_axi_bvalid && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        chk("arb_bvalid", 32'({axi.s_axi_bvalid, axi.s_axi_bresp}), 32'h4);
        chk("arb_no_read_yet", n_ior - b_ior, 0);
        axi.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        axi.s_axi_bready = 1'b0;
        rd(32'h0000_0808, 0, lat, data, resp);
        chk("arb_rdata", data, 32'h0000_0077);
        chk("arb_widths", (n_iow - b_iow) * 100 + (n_ior - b_ior), 606);

        // Reset while a write is stretched in WAIT_RDY
        isa_iochrdy = 1'b0;
        axi.s_axi_awaddr = 32'h0000_0008; axi.s_axi_wdata = 32'h0000_0042; axi.s_axi_wstrb = 4'hF;
        axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
        k = 0;
        while (!axi.s_axi_awready && k < 20) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0;
        k = 0;
        while (isa_iow_n && k < 50) begin
            @(posedge clk); #1; k++;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("rst_wait_pre", 32'({isa_iow_n, isa_data_oe, busy}), 32'h3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_wait_strobes", 32'({isa_ior_n, isa_iow_n}), 32'h3);
        chk("rst_wait_oe_busy", 32'({isa_data_oe, busy, axi.s_axi_bvalid}), 32'h0);
        isa_iochrdy = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        stale = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (axi.s_axi_bvalid || axi.s_axi_rvalid || !isa_iow_n) stale++;
        end
        chk("rst_no_stale", stale, 0);

        // First transaction after reset behaves normally
        isa_data_in = 8'h81;
        b_ior = n_ior;
        rd(32'h0000_0FD0, 0, lat, data, resp);
        chk("post_rst_rdata", data, 32'h0000_0081);
        chk("post_rst_latency", lat, 11);
        chk("post_rst_ior_width", n_ior - b_ior, 6);

        chk("no_strobe_overlap", n_both, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
